// File: rtl/ibex_pkg.sv
// Shared types for the instruction-bus arbiter slice.
// Source IDs and the default outstanding-transaction depth.
package ibex_pkg;

  typedef enum logic {
    SRC_CORE = 1'b0,
    SRC_AUX  = 1'b1
  } instr_src_e;

  // Default MaxOutstanding: two fetches in flight.
  localparam int unsigned IBUS_MAX_OUTSTANDING = 2;

endpackage

// File: rtl/ibex_instr_bus_arbiter_if.sv
// req/gnt/rvalid split-transaction instruction bus.
// master issues requests, slave grants and responds.
interface ibex_instr_bus_arbiter_if;

  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, addr,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, addr,
    output gnt, rvalid, rdata, err
  );

endinterface

// File: rtl/ibex_id_fifo.sv
// 1-bit wide source-ID FIFO with wrap-around pointers.
// Registered count, no bypass from push to pop.
module ibex_id_fifo #(
  parameter  int unsigned Depth = 2,
  localparam int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  logic            data_i,
  input  logic            pop_i,
  output logic            data_o,
  output logic [CntW-1:0] count_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

  logic [Depth-1:0] mem_q, mem_d;
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign do_push = push_i & (count_q != CntW'(Depth));
  assign do_pop  = pop_i & (count_q != '0);

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) begin
      mem_d[wptr_q] = data_i;
      wptr_d = (wptr_q == LastPtr) ? '0 : wptr_q + PtrW'(1);
    end
    if (do_pop) begin
      rptr_d = (rptr_q == LastPtr) ? '0 : rptr_q + PtrW'(1);
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign data_o  = mem_q[rptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ibex_instr_bus_arbiter.sv
// Round-robin arbiter sharing one instruction-memory port
// between the core fetch path and an auxiliary master.
module ibex_instr_bus_arbiter
  import ibex_pkg::*;
#(
  parameter int unsigned MaxOutstanding = IBUS_MAX_OUTSTANDING
) (
  input  logic clk_i,
  input  logic rst_ni,
  ibex_instr_bus_arbiter_if.slave  core,
  ibex_instr_bus_arbiter_if.slave  aux,
  ibex_instr_bus_arbiter_if.master mem,
  output logic busy_o,
  output logic protocol_err_o
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  instr_src_e      sel, sel_q, sel_d;
  instr_src_e      last_q, last_d;
  instr_src_e      head;
  logic            head_bit;
  logic            lock_q, lock_d;
  logic            perr_q, perr_d;
  logic [CntW-1:0] count;
  logic            can_issue, sel_req, any_req;
  logic            hs, pop, empty;

  // Capacity comes from registered state only: no gnt/rvalid -> req path.
  assign can_issue = count < CntW'(MaxOutstanding);
  assign empty     = count == '0;
  assign any_req   = core.req | aux.req;

  always_comb begin
    sel = instr_src_e'(~last_q);
    if (lock_q) begin
      sel = sel_q;
    end else if (core.req & ~aux.req) begin
      sel = SRC_CORE;
    end else if (aux.req & ~core.req) begin
      sel = SRC_AUX;
    end
  end

  assign sel_req = (sel == SRC_AUX) ? aux.req : core.req;

  assign mem.req  = rst_ni & can_issue & sel_req;
  assign mem.addr = !any_req         ? '0       :
                    (sel == SRC_AUX) ? aux.addr : core.addr;

  assign hs       = mem.req & mem.gnt;
  assign core.gnt = hs & (sel == SRC_CORE);
  assign aux.gnt  = hs & (sel == SRC_AUX);

  assign pop  = mem.rvalid & ~empty;
  assign head = instr_src_e'(head_bit);

  assign core.rvalid = pop & (head == SRC_CORE);
  assign core.rdata  = core.rvalid ? mem.rdata : '0;
  assign core.err    = core.rvalid & mem.err;
  assign aux.rvalid  = pop & (head == SRC_AUX);
  assign aux.rdata   = aux.rvalid ? mem.rdata : '0;
  assign aux.err     = aux.rvalid & mem.err;

  // A stalled request holds its port; a dropped req releases it.
  always_comb begin
    lock_d = mem.req & ~mem.gnt;
    sel_d  = lock_d ? sel : sel_q;
    last_d = hs ? sel : last_q;
    perr_d = perr_q | (mem.rvalid & empty);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q <= 1'b0;
      sel_q  <= SRC_CORE;
      last_q <= SRC_AUX;
      perr_q <= 1'b0;
    end else begin
      lock_q <= lock_d;
      sel_q  <= sel_d;
      last_q <= last_d;
      perr_q <= perr_d;
    end
  end

  ibex_id_fifo #(
    .Depth (MaxOutstanding)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (hs),
    .data_i  (sel),
    .pop_i   (pop),
    .data_o  (head_bit),
    .count_o (count)
  );

  assign busy_o         = ~empty;
  assign protocol_err_o = perr_q;

endmodule

// File: tb/tb_ibex_instr_bus_arbiter.sv
// Scenario bench for ibex_instr_bus_arbiter.
// Expected responses are queued at grant time, checked at rvalid.
module tb_ibex_instr_bus_arbiter;

  logic clk = 1'b0;
  logic rst_ni = 1'b1;
  logic busy, perr;

  always #5 clk = ~clk;

  ibex_instr_bus_arbiter_if core_if ();
  ibex_instr_bus_arbiter_if aux_if ();
  ibex_instr_bus_arbiter_if mem_if ();

  ibex_instr_bus_arbiter dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .core           (core_if),
    .aux            (aux_if),
    .mem            (mem_if),
    .busy_o         (busy),
    .protocol_err_o (perr)
  );

  typedef struct {
    bit          port;
    logic [31:0] data;
    bit          err;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [67:0] act, want;

  function automatic logic [67:0] exp_vec(exp_t x);
    if (x.port)
      return {1'b0, 32'h0, 1'b0, 1'b1, x.data, x.err};
    return {1'b1, x.data, x.err, 1'b0, 32'h0, 1'b0};
  endfunction

  function automatic logic [67:0] resp_vec();
    return {core_if.rvalid, core_if.rdata, core_if.err,
            aux_if.rvalid, aux_if.rdata, aux_if.err};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    core_if.req    = 1'b0;
    core_if.addr   = '0;
    aux_if.req     = 1'b0;
    aux_if.addr    = '0;
    mem_if.gnt     = 1'b0;
    mem_if.rvalid  = 1'b0;
    mem_if.rdata   = '0;
    mem_if.err     = 1'b0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    idle();
    cyc();
    cyc();
    rst_ni = 1'b1;
    sb.delete();
  endtask

  task automatic test_reset();
    #1 rst_ni = 1'b0;
    core_if.req   = 1'b1;
    core_if.addr  = 32'h10;
    aux_if.req    = 1'b1;
    aux_if.addr   = 32'h20;
    mem_if.gnt    = 1'b1;
    mem_if.rvalid = 1'b1;
    mem_if.rdata  = 32'hFFFF_FFFF;
    mem_if.err    = 1'b1;
    cyc();
    #4;
    n_cmp++;
    if ({mem_if.req, core_if.gnt, aux_if.gnt, core_if.rvalid,
         aux_if.rvalid, core_if.err, aux_if.err, busy, perr} !== 9'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl act=%b exp=0", {mem_if.req, core_if.gnt,
               aux_if.gnt, core_if.rvalid, aux_if.rvalid, busy, perr});
    end
    n_cmp++;
    if ({core_if.rdata, aux_if.rdata} !== 64'h0) begin
      n_bad++;
      $display("FAIL reset_rdata act=%h exp=0", {core_if.rdata, aux_if.rdata});
    end
    idle();
    cyc();
    rst_ni = 1'b1;
    #4;
    n_cmp++;
    if ({mem_if.req, busy, perr} !== 3'b000) begin
      n_bad++;
      $display("FAIL post_reset act=%b exp=000", {mem_if.req, busy, perr});
    end
    cyc();
  endtask

  task automatic test_core_single();
    do_reset();
    core_if.req  = 1'b1;
    core_if.addr = 32'h0000_0080;
    mem_if.gnt   = 1'b1;
    #4;
    n_cmp++;
    if ({mem_if.req, core_if.gnt, aux_if.gnt, mem_if.addr} !==
        {3'b110, 32'h0000_0080}) begin
      n_bad++;
      $display("FAIL single_issue act=%b/%h exp=110/00000080",
               {mem_if.req, core_if.gnt, aux_if.gnt}, mem_if.addr);
    end
    sb.push_back('{port: 1'b0, data: 32'h13, err: 1'b0});
    cyc();
    idle();
    #4;
    n_cmp++;
    if ({busy, core_if.rvalid, aux_if.rvalid} !== 3'b100) begin
      n_bad++;
      $display("FAIL single_wait act=%b exp=100",
               {busy, core_if.rvalid, aux_if.rvalid});
    end
    cyc();
    mem_if.rvalid = 1'b1;
    mem_if.rdata  = 32'h0000_0013;
    #4;
    e    = sb.pop_front();
    want = exp_vec(e);
    act  = resp_vec();
    n_cmp++;
    if ({busy, act} !== {1'b1, want}) begin
      n_bad++;
      $display("FAIL single_resp act=%h exp=%h", {busy, act}, {1'b1, want});
    end
    cyc();
    idle();
    #4;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL single_idle busy act=%b exp=0", busy);
    end
    cyc();
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int k = 0; k <= 6; k++) begin
      idle();
      if (k < 6) begin
        core_if.req  = 1'b1;
        core_if.addr = 32'h100 + 32'(4 * k);
        aux_if.req   = 1'b1;
        aux_if.addr  = 32'h2000 + 32'(4 * k);
        mem_if.gnt   = 1'b1;
      end
      if (k > 0) begin
        mem_if.rvalid = 1'b1;
        mem_if.rdata  = 32'hD000_0000 + 32'(k - 1);
        mem_if.err    = (k - 1 == 2);
      end
      #4;
      if (k < 6) begin
        n_cmp++;
        if ({core_if.gnt, aux_if.gnt, mem_if.addr} !==
            {(k % 2 == 0), (k % 2 == 1),
             (k % 2 == 0) ? core_if.addr : aux_if.addr}) begin
          n_bad++;
          $display("FAIL rr_grant k=%0d act=%b%b/%h", k,
                   core_if.gnt, aux_if.gnt, mem_if.addr);
        end
        sb.push_back('{port: (k % 2 == 1),
                       data: 32'hD000_0000 + 32'(k),
                       err: (k == 2)});
      end
      if (k > 0) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL rr_resp k=%0d act=rvalid exp=none queued", k);
        end else begin
          e    = sb.pop_front();
          want = exp_vec(e);
          act  = resp_vec();
          if (act !== want) begin
            n_bad++;
            $display("FAIL rr_resp k=%0d act=%h exp=%h", k, act, want);
          end
        end
      end
      cyc();
    end
    idle();
  endtask

  task automatic test_lock();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      aux_if.req   = 1'b1;
      aux_if.addr  = 32'h1A11_0800;
      core_if.req  = (c >= 1);
      core_if.addr = 32'h8000_0000;
      mem_if.gnt   = (c == 3);
      #4;
      n_cmp++;
      if ({mem_if.req, aux_if.gnt, core_if.gnt, mem_if.addr} !==
          {1'b1, (c == 3), 1'b0, 32'h1A11_0800}) begin
        n_bad++;
        $display("FAIL lock_hold c=%0d act=%b%b%b/%h exp=1%0b0/1a110800", c,
                 mem_if.req, aux_if.gnt, core_if.gnt, mem_if.addr, (c == 3));
      end
      cyc();
    end
    sb.push_back('{port: 1'b1, data: 32'hAAAA_0001, err: 1'b0});
    aux_if.req = 1'b0;
    mem_if.gnt = 1'b1;
    #4;
    n_cmp++;
    if ({core_if.gnt, aux_if.gnt, mem_if.addr} !== {2'b10, 32'h8000_0000}) begin
      n_bad++;
      $display("FAIL lock_next act=%b%b/%h exp=10/80000000",
               core_if.gnt, aux_if.gnt, mem_if.addr);
    end
    sb.push_back('{port: 1'b0, data: 32'hCCCC_0002, err: 1'b0});
    cyc();
    for (int r = 0; r < 2; r++) begin
      idle();
      mem_if.rvalid = 1'b1;
      mem_if.rdata  = (r == 0) ? 32'hAAAA_0001 : 32'hCCCC_0002;
      #4;
      e    = sb.pop_front();
      want = exp_vec(e);
      act  = resp_vec();
      n_cmp++;
      if (act !== want) begin
        n_bad++;
        $display("FAIL lock_resp r=%0d act=%h exp=%h", r, act, want);
      end
      cyc();
    end
    idle();
    #4;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL lock_idle busy act=%b exp=0", busy);
    end
    cyc();
  endtask

  task automatic test_full();
    do_reset();
    for (int c = 0; c < 7; c++) begin
      idle();
      core_if.req  = (c <= 4);
      core_if.addr = 32'h300 + 32'(4 * c);
      mem_if.gnt   = 1'b1;
      if (c == 3 || c == 5 || c == 6) begin
        mem_if.rvalid = 1'b1;
        mem_if.rdata  = 32'hF000_0000 + 32'(c);
      end
      #4;
      n_cmp++;
      if ({mem_if.req, core_if.gnt} !==
          {2{(c <= 1) || (c == 4)}}) begin
        n_bad++;
        $display("FAIL full_req c=%0d act=%b%b exp=%0b", c,
                 mem_if.req, core_if.gnt, (c <= 1) || (c == 4));
      end
      if (mem_if.rvalid) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL full_resp c=%0d act=rvalid exp=none queued", c);
        end else begin
          e      = sb.pop_front();
          e.data = mem_if.rdata;
          want   = exp_vec(e);
          act    = resp_vec();
          if (act !== want) begin
            n_bad++;
            $display("FAIL full_resp c=%0d act=%h exp=%h", c, act, want);
          end
        end
      end
      if ((c <= 1) || (c == 4))
        sb.push_back('{port: 1'b0, data: 32'h0, err: 1'b0});
      cyc();
    end
    idle();
    #4;
    n_cmp++;
    if ({busy, sb.size() == 0} !== 2'b01) begin
      n_bad++;
      $display("FAIL full_drain busy act=%b exp=0 left=%0d", busy, sb.size());
    end
    cyc();
  endtask

  task automatic test_protocol_err();
    do_reset();
    mem_if.rvalid = 1'b1;
    mem_if.rdata  = 32'h0000_DEAD;
    #4;
    n_cmp++;
    if ({core_if.rvalid, aux_if.rvalid, perr} !== 3'b000) begin
      n_bad++;
      $display("FAIL perr_drop act=%b exp=000",
               {core_if.rvalid, aux_if.rvalid, perr});
    end
    cyc();
    idle();
    for (int c = 0; c < 3; c++) begin
      #4;
      n_cmp++;
      if ({perr, busy} !== 2'b10) begin
        n_bad++;
        $display("FAIL perr_sticky c=%0d act=%b exp=10", c, {perr, busy});
      end
      cyc();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    core_if.req  = 1'b1;
    core_if.addr = 32'h40;
    mem_if.gnt   = 1'b1;
    cyc();
    idle();
    #4;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_busy act=%b exp=1", busy);
    end
    #2 rst_ni = 1'b0;
    core_if.req = 1'b1;
    aux_if.req  = 1'b1;
    mem_if.gnt  = 1'b1;
    #1;
    n_cmp++;
    if ({mem_if.req, core_if.gnt, aux_if.gnt, core_if.rvalid,
         aux_if.rvalid, busy, perr} !== 7'b0) begin
      n_bad++;
      $display("FAIL mid_reset act=%b exp=0", {mem_if.req, core_if.gnt,
               aux_if.gnt, core_if.rvalid, aux_if.rvalid, busy, perr});
    end
    cyc();
    cyc();
    idle();
    rst_ni = 1'b1;
    cyc();
    mem_if.rvalid = 1'b1;
    mem_if.rdata  = 32'h0000_0055;
    #4;
    n_cmp++;
    if ({core_if.rvalid, aux_if.rvalid, perr} !== 3'b000) begin
      n_bad++;
      $display("FAIL mid_late act=%b exp=000",
               {core_if.rvalid, aux_if.rvalid, perr});
    end
    cyc();
    idle();
    #4;
    n_cmp++;
    if ({perr, busy} !== 2'b10) begin
      n_bad++;
      $display("FAIL mid_perr act=%b exp=10", {perr, busy});
    end
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    test_reset();
    test_core_single();
    test_round_robin();
    test_lock();
    test_full();
    test_protocol_err();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
